// File: rtl/axi_sram_pkg.sv
// Shared types and widths for the AXI-style SRAM subordinate.
// One burst is always a 16-byte line of four 32-bit beats.
package axi_sram_pkg;

    localparam int BEATS  = 4;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int ATOP_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WRESP,
        S_RFETCH,
        S_RDATA
    } state_t;

    function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
        return beat == BEAT_W'(BEATS - 1);
    endfunction

endpackage

// File: rtl/sram_1rw_bytewe.sv
// Single-port word memory with byte write enables and registered read.
// A read is performed only when enabled with no byte enables set.
module sram_1rw_bytewe #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read port holds its value between reads so a stalled beat stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && we == '0) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_sram_subordinate.sv
// AXI-style line-burst subordinate in front of a single-port SRAM.
// One transaction at a time; a write wins over a simultaneous read.
module axi_sram_subordinate
    import axi_sram_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [ATOP_W-1:0] awatop,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic              bcomp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic              rlast
);

    localparam int LINE_W = MEM_AW - BEAT_W;

    state_t              state;
    logic                idle_q;
    logic [BEAT_W-1:0]   beat;
    logic [LINE_W-1:0]   line;
    logic                atomic_q;
    logic [ID_W-1:0]     bid_q;
    logic [ID_W-1:0]     rid_q;
    logic                bvalid_q;
    logic                bcomp_q;
    logic                rvalid_q;
    logic                rlast_q;

    logic                w_beat;
    logic                mem_en;
    logic [STRB_W-1:0]   mem_we;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic                unused_addr;

    // Offset-in-line and bits above the memory size are ignored.
    assign unused_addr = ^{awaddr[ADDR_W-1:MEM_AW+2], awaddr[3:0],
                           araddr[ADDR_W-1:MEM_AW+2], araddr[3:0]};

    assign awready = idle_q;
    assign arready = idle_q & ~awvalid;
    assign wready  = (state == S_WDATA);
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bcomp   = bcomp_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rlast   = rlast_q;
    assign rdata   = rvalid_q ? mem_rdata : '0;

    always_comb begin
        w_beat   = (state == S_WDATA) && wvalid;
        mem_we   = (w_beat && !atomic_q) ? wstrb : '0;
        mem_en   = (state == S_RFETCH) || (mem_we != '0);
        mem_addr = {line, beat};
    end

    sram_1rw_bytewe #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idle_q   <= 1'b0;
            beat     <= '0;
            line     <= '0;
            atomic_q <= 1'b0;
            bid_q    <= '0;
            rid_q    <= '0;
            bvalid_q <= 1'b0;
            bcomp_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    idle_q <= 1'b1;
                    if (idle_q && awvalid) begin
                        state    <= S_WDATA;
                        idle_q   <= 1'b0;
                        beat     <= '0;
                        line     <= awaddr[MEM_AW+1:4];
                        atomic_q <= (awatop != '0);
                        bid_q    <= awid;
                    end else if (idle_q && arvalid) begin
                        state  <= S_RFETCH;
                        idle_q <= 1'b0;
                        beat   <= '0;
                        line   <= araddr[MEM_AW+1:4];
                        rid_q  <= arid;
                    end
                end
                S_WDATA: begin
                    if (wvalid) begin
                        if (wlast || is_last_beat(beat)) begin
                            // Only a well-formed, non-atomic burst completes OK.
                            state    <= S_WRESP;
                            bvalid_q <= 1'b1;
                            bcomp_q  <= wlast && is_last_beat(beat)
                                        && !atomic_q;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                S_WRESP: begin
                    if (bready) begin
                        state    <= S_IDLE;
                        idle_q   <= 1'b1;
                        bvalid_q <= 1'b0;
                        bcomp_q  <= 1'b0;
                    end
                end
                S_RFETCH: begin
                    state    <= S_RDATA;
                    rvalid_q <= 1'b1;
                    rlast_q  <= is_last_beat(beat);
                end
                S_RDATA: begin
                    if (rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (is_last_beat(beat)) begin
                            state  <= S_IDLE;
                            idle_q <= 1'b1;
                        end else begin
                            state <= S_RFETCH;
                            beat  <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    idle_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_subordinate.sv
// Directed bench for axi_sram_subordinate: bursts, strobes, errors,
// arbitration, back-pressure and reset during a read.
module tb_axi_sram_subordinate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [5:0]  awatop;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic        bcomp;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] wdat [4];
    logic [3:0]  wstb [4];
    logic [31:0] rexp [4];

    always #5 clk = ~clk;

    axi_sram_subordinate #(.MEM_AW(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .awvalid (awvalid),
        .awready (awready),
        .awid    (awid),
        .awaddr  (awaddr),
        .awatop  (awatop),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .bvalid  (bvalid),
        .bready  (bready),
        .bid     (bid),
        .bcomp   (bcomp),
        .arvalid (arvalid),
        .arready (arready),
        .arid    (arid),
        .araddr  (araddr),
        .rvalid  (rvalid),
        .rready  (rready),
        .rid     (rid),
        .rdata   (rdata),
        .rlast   (rlast)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {awready, arready, wready, bvalid, bcomp, bid,
                    rvalid, rlast, rid, rdata}, 64'd0);
    endtask

    task automatic set_w(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [3:0] s);
        wdat[0] = a; wdat[1] = b; wdat[2] = c; wdat[3] = d;
        for (int i = 0; i < 4; i++) wstb[i] = s;
    endtask

    task automatic set_r(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        rexp[0] = a; rexp[1] = b; rexp[2] = c; rexp[3] = d;
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] a,
                            input logic [5:0] atop);
        int n;
        n = 0;
        awvalid = 1'b1; awid = id; awaddr = a; awatop = atop;
        #1;
        while (!awready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("aw_ready", awready, 1);
        cyc();
        awvalid = 1'b0;
    endtask

    task automatic w_phase(input int nb, input bit last);
        int n;
        for (int i = 0; i < nb; i++) begin
            n = 0;
            wvalid = 1'b1; wdata = wdat[i]; wstrb = wstb[i];
            wlast = last && (i == nb - 1);
            #1;
            while (!wready && n < 20) begin
                @(negedge clk); #1; n++;
            end
            check($sformatf("w_ready%0d", i), wready, 1);
            cyc();
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [3:0] id, input logic comp);
        int n;
        n = 0;
        #1;
        while (!bvalid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("b_valid", bvalid, 1);
        check("b_id", bid, id);
        check("b_comp", bcomp, comp);
        cyc();
        check("b_hold", {bvalid, bid, bcomp}, {1'b1, id, comp});
        bready = 1'b1;
        cyc();
        bready = 1'b0;
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] a);
        int n;
        n = 0;
        arvalid = 1'b1; arid = id; araddr = a;
        #1;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("ar_ready", arready, 1);
        cyc();
        arvalid = 1'b0;
        #1;
        check("r_lat0", rvalid, 0);
        cyc();
        check("r_lat1", rvalid, 1);
    endtask

    task automatic r_phase(input logic [3:0] id, input int stall_beat,
                           input int stall_n);
        int n;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!rvalid && n < 20) begin
                @(negedge clk); n++;
            end
            check($sformatf("r_data%0d", i), rdata, rexp[i]);
            check($sformatf("r_id%0d", i), rid, id);
            check($sformatf("r_last%0d", i), rlast, (i == 3));
            if (i == stall_beat) begin
                for (int k = 0; k < stall_n; k++) begin
                    cyc();
                    check($sformatf("r_stall%0d", k), {rvalid, rdata},
                          {1'b1, rexp[i]});
                end
            end
            rready = 1'b1;
            cyc();
            rready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a,
                            input logic [5:0] atop, input int nb,
                            input bit last, input logic comp);
        aw_phase(id, a, atop);
        w_phase(nb, last);
        b_phase(id, comp);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a);
        ar_phase(id, a);
        r_phase(id, -1, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        awvalid = 0; awid = 0; awaddr = 0; awatop = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
        bready = 0; arvalid = 0; arid = 0; araddr = 0; rready = 0;
        repeat (3) cyc();
        check_zero("rst_outs");
        rst_n = 1'b1;
        #1;
        check("idle_lo", awready, 0);
        cyc();
        check("idle_hi", {awready, arready}, 2'b11);

        // Full line write then readback
        set_w(32'h11, 32'h22, 32'h33, 32'h44, 4'hF);
        do_write(4'd3, 32'h100, 6'd0, 4, 1'b1, 1'b1);
        set_r(32'h11, 32'h22, 32'h33, 32'h44);
        do_read(4'd5, 32'h100);

        // Simultaneous AW/AR: write first, read waits for bready
        set_w(32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'hF);
        awvalid = 1; awid = 4'd6; awaddr = 32'h200; awatop = 0;
        arvalid = 1; arid = 4'd7; araddr = 32'h200;
        #1;
        check("sim_aw", awready, 1);
        check("sim_ar", arready, 0);
        cyc();
        awvalid = 1'b0;
        #1;
        check("sim_ar_wd", arready, 0);
        w_phase(4, 1'b1);
        #1;
        check("sim_ar_wr", arready, 0);
        b_phase(4'd6, 1'b1);
        #1;
        check("sim_ar_go", arready, 1);
        set_r(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        ar_phase(4'd7, 32'h200);
        r_phase(4'd7, -1, 0);

        // Byte strobes
        set_w(32'h12345678, 32'h0, 32'h0, 32'h0, 4'hF);
        do_write(4'd1, 32'h300, 6'd0, 4, 1'b1, 1'b1);
        set_w(32'hAABBCCDD, 32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);
        wstb[0] = 4'h1;
        wstb[1] = 4'hA;
        do_write(4'd2, 32'h300, 6'd0, 4, 1'b1, 1'b1);
        set_r(32'h123456DD, 32'h11003300, 32'h0, 32'h0);
        do_read(4'd2, 32'h300);

        // Early wlast: error, but beats still land
        set_w(32'h1, 32'h2, 32'h3, 32'h4, 4'hF);
        do_write(4'd4, 32'h400, 6'd0, 4, 1'b1, 1'b1);
        set_w(32'h9, 32'h9, 32'h0, 32'h0, 4'hF);
        do_write(4'd4, 32'h400, 6'd0, 2, 1'b1, 1'b0);
        set_r(32'h9, 32'h9, 32'h3, 32'h4);
        do_read(4'd4, 32'h400);

        // Missing wlast on beat 4
        set_w(32'h5, 32'h6, 32'h7, 32'h8, 4'hF);
        do_write(4'd8, 32'h500, 6'd0, 4, 1'b0, 1'b0);
        set_r(32'h5, 32'h6, 32'h7, 32'h8);
        do_read(4'd8, 32'h500);

        // Atomic: error, memory untouched
        set_w(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF);
        do_write(4'd9, 32'h100, 6'd1, 4, 1'b1, 1'b0);
        set_r(32'h11, 32'h22, 32'h33, 32'h44);
        do_read(4'd9, 32'h100);

        // Address wrap and ignored line offset
        do_read(4'd10, 32'h0000_4108);

        // Back-pressure on beat 1
        ar_phase(4'd11, 32'h100);
        r_phase(4'd11, 1, 5);

        // Reset in the middle of a read
        set_r(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        ar_phase(4'd12, 32'h200);
        rst_n = 1'b0;
        #1;
        check_zero("rst_rd");
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        do_read(4'd13, 32'h200);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_sram_subordinate.md
AXI_SRAM_SUBORDINATE -- requirements
Module: axi_sram_subordinate

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, word-address width (2^MEM_AW 32-bit words).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 awvalid  in  1  write request valid.
REQ-005 awready  out  1  write request accepted.
REQ-006 awid  in  4  write transaction ID.
REQ-007 awaddr  in  32  write byte address, 16-byte line.
REQ-008 awatop  in  6  atomic opcode; 0 = plain write.
REQ-009 wvalid  in  1  write beat valid.
REQ-010 wready  out  1  write beat accepted.
REQ-011 wdata  in  32  write beat data.
REQ-012 wstrb  in  4  byte enables.
REQ-013 wlast  in  1  final write beat.
REQ-014 bvalid  out  1  write response valid.
REQ-015 bready  in  1  write response accepted.
REQ-016 bid  out  4  response ID (captured awid).
REQ-017 bcomp  out  1  1 = completed OK, 0 = error.
REQ-018 arvalid  in  1  read request valid.
REQ-019 arready  out  1  read request accepted.
REQ-020 arid  in  4  read transaction ID.
REQ-021 araddr  in  32  read byte address, 16-byte line.
REQ-022 rvalid  out  1  read beat valid.
REQ-023 rready  in  1  read beat accepted.
REQ-024 rid  out  4  read ID (captured arid).
REQ-025 rdata  out  32  read beat data.
REQ-026 rlast  out  1  final read beat.

Function
REQ-027 SHALL use one FSM: IDLE, WDATA, WRESP, RFETCH, RDATA. Single-port synchronous-read word memory.
REQ-028 SHALL drive awready = idle_q and arready = idle_q & !awvalid, where idle_q is a registered flag high only in IDLE. Write wins a simultaneous request.
REQ-029 SHALL capture ID and address on AW handshake, IDLE->WDATA, beat counter = 0. Word index = {addr[MEM_AW+1:4], beat[1:0]}. addr[3:0] and upper bits are ignored, so addresses wrap modulo memory size.
REQ-030 In WDATA, wready = 1. Each wvalid beat writes the wstrb-enabled bytes; wstrb = 0 writes nothing.
REQ-031 The burst SHALL end on wlast or on the 4th beat, whichever comes first, then go to WRESP.
REQ-032 bcomp SHALL be 0 if wlast arrives early, if wlast is absent on beat 4, or if awatop != 0. For awatop != 0, beats are consumed but no memory bytes change.
REQ-033 In WRESP, bvalid = 1 and bid and bcomp are held stable until bready; the bready cycle returns the FSM to IDLE.
REQ-034 AR handshake SHALL go IDLE->RFETCH (memory read issued) ->RDATA. rvalid first rises 2 cycles after the handshake cycle.
REQ-035 In RDATA, rvalid = 1 with rdata, rid and rlast (beat 3) held until rready. On rready: beat < 3 goes to RFETCH with beat+1; beat 3 goes to IDLE.
REQ-036 Read-after-write to the same word SHALL return the new data. Outputs are never X after reset.

Reset
REQ-037 On rst_n low: state IDLE, idle_q 0, all outputs 0 (awready/arready included), beat counter 0. Any transaction in progress is abandoned. Memory contents are not reset. idle_q rises the first clock after release.

Structure
REQ-038 Package axi_sram_pkg SHALL hold the state enum, BEATS = 4 and the ID/addr/data widths. Sub-module sram_1rw_bytewe holds the byte-enabled synchronous memory.

Verification
REQ-039 Write line 0x100: data 11,22,33,44, wstrb F, wlast on beat 4 -> bvalid with bid = awid and bcomp = 1. Read 0x100 -> 11,22,33,44, rlast on beat 4, rid = arid.
REQ-040 awvalid and arvalid rise in the same cycle -> write accepted first; arready is 0 that cycle; read accepted only after bready.
REQ-041 wstrb 0x1 with wdata 0xAABBCCDD over word 0x12345678 -> reads 0x123456DD.
REQ-042 wlast on beat 2 -> bcomp = 0. awatop = 1 -> bcomp = 0 and the memory is unchanged on readback.
REQ-043 rready held low for 5 cycles on beat 1 -> rvalid and rdata stable throughout. rst_n pulsed low in mid-RDATA -> all outputs 0, then a fresh read succeeds.
